instr_fetch: RTL

Instruction fetch stage that sits directly upstream of the R-type compute stage (register-file read plus ALU). Holds the PC and issues word reads to a synchronous instruction memory. Buffers the returned words in a 2-entry queue and presents them, one per handshake, as the 32-bit instruction word consumed downstream. Fetch starts on a start pulse and stops on a halt sentinel word.

---
 rtl/instr_fetch_pkg.sv | 20 ++
 rtl/instr_fetch_queue.sv | 60 ++++++
 rtl/instr_fetch.sv | 91 +++++++++
 3 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
//   state_t : fetch FSM encoding (IDLE/FETCH/DRAIN/HALT)
//   qent_t  : queue entry, {pc, instr}
package instr_fetch_pkg;
   localparam int          WORD_W        = 32;
   localparam logic [31:0] PC_INC        = 32'd4;
   localparam logic [31:0] DEF_HALT_WORD = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_DRAIN = 2'd2,
      S_HALT  = 2'd3
   } state_t;

   typedef struct packed {
      logic [WORD_W-1:0] pc;
      logic [WORD_W-1:0] instr;
   } qent_t;
endpackage

// File: rtl/instr_fetch_queue.sv
// fetch_queue: 2-entry synchronous FIFO of {pc, instr}.
// Head is always slot e0 (registered), so the consumer never sees a
// combinational path from the write data.
//   clk, rst   : clock, synchronous active-high reset
//   push, din  : write din at tail
//   pop        : drop head (ignored when empty)
//   full/empty : occupancy flags; count : 0..2
//   head       : entry at queue head
module fetch_queue
   import instr_fetch_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       push,
   input  qent_t      din,
   input  logic       pop,
   output logic       full,
   output logic       empty,
   output logic [1:0] count,
   output qent_t      head
);
   qent_t      e0, e1;
   logic [1:0] cnt;
   logic       do_pop;

   assign do_pop = pop & (cnt != 2'd0);
   assign full   = (cnt == 2'd2);
   assign empty  = (cnt == 2'd0);
   assign count  = cnt;
   assign head   = e0;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= 2'd0;
         e0  <= '0;
         e1  <= '0;
      end else begin
         case ({push, do_pop})
            2'b10: begin
               if (cnt == 2'd0) e0 <= din;
               else             e1 <= din;
               cnt <= cnt + 2'd1;
            end
            2'b01: begin
               e0  <= e1;
               cnt <= cnt - 2'd1;
            end
            2'b11: begin
               // count is unchanged; the new word lands behind whatever remains
               if (cnt == 2'd1) e0 <= din;
               else begin
                  e0 <= e1;
                  e1 <= din;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: PC, request credit and FSM for the fetch stage.
//   start                  : begin fetch at BASE_ADDR (IDLE/HALT only)
//   imem_en/imem_addr      : read request; imem_rdata returns one cycle later
//   instr/instr_pc/valid   : queue head to downstream, taken on instr_ready
//   busy/halted            : FETCH|DRAIN / HALT status
module instr_fetch
   import instr_fetch_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter logic [31:0] HALT_WORD = DEF_HALT_WORD
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic        imem_en,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic        busy,
   output logic        halted
);
   state_t      state, state_nx;
   logic [31:0] pc, req_pc;
   logic        inflight;
   logic        pop, rsp_halt, rsp_push, credit;
   logic [1:0]  q_count, occ_after;
   logic        q_full, q_empty;
   qent_t       head;

   assign pop       = instr_valid & instr_ready;
   // credit counts the slot freed by this cycle's pop, so ready=1 streams 1/cycle
   assign occ_after = q_count - {1'b0, pop};
   assign credit    = ({1'b0, occ_after} + {2'b00, inflight}) < 3'd2;
   assign rsp_halt  = inflight & (imem_rdata == HALT_WORD);
   assign rsp_push  = inflight & ~rsp_halt;

   // A halt response blocks the request that would otherwise go out beside it,
   // so nothing is outstanding once DRAIN is entered.
   assign imem_en   = (state == S_FETCH) & credit & ~rsp_halt;
   assign imem_addr = pc;

   assign instr       = head.instr;
   assign instr_pc    = head.pc;
   assign instr_valid = ~q_empty;
   assign busy        = (state == S_FETCH) | (state == S_DRAIN);
   assign halted      = (state == S_HALT);

   fetch_queue u_q (
      .clk   (clk),
      .rst   (rst),
      .push  (rsp_push & (~q_full | pop)),
      .din   ({req_pc, imem_rdata}),
      .pop   (pop),
      .full  (q_full),
      .empty (q_empty),
      .count (q_count),
      .head  (head)
   );

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE,
         S_HALT:  if (start)    state_nx = S_FETCH;
         S_FETCH: if (rsp_halt) state_nx = S_DRAIN;
         S_DRAIN: if (q_empty)  state_nx = S_HALT;
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         pc       <= BASE_ADDR;
         req_pc   <= '0;
         inflight <= 1'b0;
      end else begin
         state    <= state_nx;
         inflight <= imem_en;
         if (imem_en) begin
            req_pc <= pc;
            pc     <= pc + PC_INC;   // wraps modulo 2^32
         end else if (((state == S_IDLE) || (state == S_HALT)) && start) begin
            pc <= BASE_ADDR;
         end
      end
   end
endmodule
